cpu_program_feeder: RTL
=======================

Name: cpu_program_feeder

Overview:
- Instruction source and sequencer that drives the 16-bit CPU's run/din handshake and consumes its done.
- Holds a small writable program memory and issues instructions one at a time.
- Supplies the immediate word for mvi, and stalls until the CPU reports done.
- Sits between the testbench or top level and the CPU, replacing hand-driven run/din stimulus.

Parameters:
DEPTH, 32, program memory words (power of two)
ADDR_W, 5, log2(DEPTH)
TIMEOUT, 16, max cycles waiting for done before error

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous, active-low reset
prog_we  input  1  program memory write strobe (honoured only when busy=0)
prog_addr  input  ADDR_W  write address
prog_wdata  input  16  write data
prog_len  input  ADDR_W+1  number of words to execute (0..DEPTH), sampled on start
start  input  1  begin execution at address 0 (honoured only when busy=0)
done  input  1  CPU instruction-complete flag
din  output  16  word presented to CPU
run  output  1  one-cycle instruction-issue pulse
busy  output  1  sequencer active
finished  output  1  program completed normally; level, held until next start
error  output  1  timeout or malformed program; level, held until next start
pc  output  ADDR_W  address of current instruction
instr_count  output  16  instructions completed since start (wraps at 16'hFFFF)

Behaviour:
- Reset (async, resetn=0): state=IDLE; din=0, run=0, busy=0, finished=0, error=0, pc=0, instr_count=0, timer=0, latched length=0. Memory contents are not reset.
- Memory read is combinational (word = mem[addr]). A write lands at the clock edge.
- Instruction format: din[8:6]=opcode. Opcode 3'b001 (mvi) is two words: instruction, then immediate. Word 16'hFFFF is HALT.
- States: IDLE, ISSUE, WAIT, ADVANCE, FIN, ERR.
- IDLE:
  - On start=1: latch prog_len; pc=0, instr_count=0, finished=0, error=0; go to ISSUE.
  - If prog_len=0, go directly to FIN instead.
- ISSUE (1 cycle):
  - run=1, din=mem[pc], busy=1, timer=0.
  - If mem[pc]=16'hFFFF: no run pulse; go to FIN.
  - If opcode=mvi and pc+1 >= length: no run pulse; go to ERR.
  - Otherwise go to WAIT.
- WAIT:
  - run=0. din=mem[pc+1] if mvi, else mem[pc].
  - done is sampled only in this state. done in the ISSUE cycle is ignored.
  - On done=1: instr_count+1; go to ADVANCE.
  - Otherwise timer+1. When timer reaches TIMEOUT-1 without done, go to ERR.
- ADVANCE (1 cycle):
  - pc += 2 if mvi, else 1.
  - If new pc >= length: go to FIN. Otherwise go to ISSUE.
  - din holds its previous value.
- FIN: finished=1, busy=0, run=0, din=0; go to IDLE.
- ERR: error=1, busy=0, run=0, din=0; go to IDLE.
- Latency: start to first run is 1 cycle. done to next run is 2 cycles (ADVANCE, ISSUE).
- run is never asserted on two consecutive cycles.
- busy=1 in ISSUE, WAIT and ADVANCE only.
- Simultaneous start and prog_we in IDLE: the write is committed and start is honoured. The first ISSUE reads the newly written word.
- prog_we and start while busy are ignored.
- pc arithmetic is ADDR_W+1 wide for comparison; the pc output is the low ADDR_W bits.
- Deassertion of resetn mid-program aborts immediately. No run pulse occurs during reset.

Test Plan:
- Load mem[0]=16'h0040 (mvi r0), mem[1]=16'h0005, mem[2]=16'h0008 (mv r1,r0); prog_len=3, start; CPU model asserts done 3 cycles after run -> run pulses for words 0 and 2 only; din=16'h0005 during first WAIT; instr_count=2; finished=1; pc final=3.
- prog_len=0, start -> finished=1 the cycle after start; run never asserted; busy stays 0.
- mem[0]=16'hFFFF, prog_len=4, start -> no run; finished=1; instr_count=0.
- mem[0]=16'h0040, prog_len=1 (mvi truncated) -> error=1, no run pulse, finished=0.
- done held low after run -> error=1 exactly TIMEOUT cycles after WAIT entry; a following start with a good program clears error.
- resetn pulsed low during WAIT -> outputs at reset values immediately (async); memory preserved; re-start executes the program correctly. prog_we during busy does not alter memory (verify by readback through a subsequent run).

Source files
------------

// File: rtl/cpu_program_feeder.sv
// cpu_program_feeder
// Instruction source and sequencer for the 16-bit CPU. A small writable
// program memory is loaded while idle. After start, the words are issued one
// at a time on the run/din handshake. The sequencer waits for the CPU's done
// before it moves on, and it supplies the immediate word for mvi.
//
// Ports:
//   clk, resetn     rising-edge clock, asynchronous active-low reset
//   prog_we/addr/wdata  program memory write port (ignored while busy)
//   prog_len        number of words to execute, sampled on start
//   start           begin execution at address 0 (ignored while busy)
//   done            CPU instruction-complete flag, sampled only while waiting
//   din             word presented to the CPU
//   run             one-cycle instruction-issue pulse
//   busy            sequencer active (issue / wait / advance)
//   finished, error completion status, held until the next start
//   pc              address of the current instruction
//   instr_count     instructions completed since start
module cpu_program_feeder #(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_wdata,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [15:0]       din,
    output logic              run,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count
);

    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]    PC_ONE     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]    PC_TWO     = (ADDR_W + 1)'(2);
    localparam logic [2:0]         OP_MVI     = 3'b001;
    localparam logic [15:0]        HALT_WORD  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FIN,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         din_q, din_d;
    logic                run_q, run_d;
    logic                busy_q, busy_d;
    logic                finished_q, finished_d;
    logic                error_q, error_d;
    logic [ADDR_W:0]     pc_q, pc_d;
    logic [15:0]         count_q, count_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ADDR_W:0]     len_q, len_d;

    logic [15:0]         mem [DEPTH];

    logic [15:0]         cur_word;
    logic                cur_is_mvi;
    logic [ADDR_W:0]     pc_plus1;
    logic [ADDR_W:0]     adv_pc;
    logic [15:0]         adv_word;
    logic [15:0]         first_word;

    // A word gets a run pulse unless it is HALT or an mvi whose immediate
    // would fall past the end of the program.
    function automatic logic issue_ok(input logic [15:0]     word,
                                      input logic [ADDR_W:0] addr,
                                      input logic [ADDR_W:0] len);
        logic truncated;
        truncated = (word[8:6] == OP_MVI) && ((addr + PC_ONE) >= len);
        return (word != HALT_WORD) && !truncated;
    endfunction

    // Program memory: writes only while idle, reads are combinational.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    assign cur_word   = mem[pc_q[ADDR_W-1:0]];
    assign cur_is_mvi = (cur_word[8:6] == OP_MVI);
    assign pc_plus1   = pc_q + PC_ONE;
    assign adv_pc     = cur_is_mvi ? (pc_q + PC_TWO) : pc_plus1;
    assign adv_word   = mem[adv_pc[ADDR_W-1:0]];

    // A write to address 0 in the same cycle as start lands on the same edge
    // that enters ISSUE, so forward it to the first issued word.
    assign first_word = (prog_we && (prog_addr == '0)) ? prog_wdata : mem[0];

    // Outputs are registered, so each transition loads the values the next
    // state presents. This includes a look-ahead of the word about to be
    // issued to decide its run pulse.
    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        run_d      = 1'b0;
        busy_d     = busy_q;
        finished_d = finished_q;
        error_d    = error_q;
        pc_d       = pc_q;
        count_d    = count_q;
        timer_d    = timer_q;
        len_d      = len_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = prog_len;
                    pc_d       = '0;
                    count_d    = '0;
                    timer_d    = '0;
                    finished_d = 1'b0;
                    error_d    = 1'b0;
                    if (prog_len == '0) begin
                        state_d    = S_FIN;
                        finished_d = 1'b1;
                        busy_d     = 1'b0;
                        din_d      = '0;
                    end else begin
                        state_d = S_ISSUE;
                        busy_d  = 1'b1;
                        din_d   = first_word;
                        run_d   = issue_ok(first_word, '0, prog_len);
                    end
                end
            end

            S_ISSUE: begin
                if (cur_word == HALT_WORD) begin
                    state_d    = S_FIN;
                    finished_d = 1'b1;
                    busy_d     = 1'b0;
                    din_d      = '0;
                end else if (cur_is_mvi && (pc_plus1 >= len_q)) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    din_d   = '0;
                end else begin
                    state_d = S_WAIT;
                    timer_d = '0;
                    din_d   = cur_is_mvi ? mem[pc_plus1[ADDR_W-1:0]] : cur_word;
                end
            end

            S_WAIT: begin
                if (done) begin
                    state_d = S_ADVANCE;
                    count_d = count_q + 16'd1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    din_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ADVANCE: begin
                pc_d = adv_pc;
                if (adv_pc >= len_q) begin
                    state_d    = S_FIN;
                    finished_d = 1'b1;
                    busy_d     = 1'b0;
                    din_d      = '0;
                end else begin
                    state_d = S_ISSUE;
                    timer_d = '0;
                    din_d   = adv_word;
                    run_d   = issue_ok(adv_word, adv_pc, len_q);
                end
            end

            S_FIN, S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                din_d   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            din_q      <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            error_q    <= 1'b0;
            pc_q       <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            error_q    <= error_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            len_q      <= len_d;
        end
    end

    assign din         = din_q;
    assign run         = run_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign error       = error_q;
    assign pc          = pc_q[ADDR_W-1:0];
    assign instr_count = count_q;

endmodule
